// File: rtl/t_flipflop_bank.sv
// t_flipflop_bank: a bank of WIDTH T flip-flops sharing one clock and reset.
//   mode=0 : each bit toggles on its own effective toggle input tt[i].
//   mode=1 : the bank is a synchronous up-counter advanced by tt[0].
// Also provides a synchronous parallel load, a global enable and a
// registered one-cycle wrap pulse when the counter rolls from all-ones to 0.
// Priority at each rising edge: load > en=0 hold > mode action.
//
// Optional feature macro: TFF_EDGE_DETECT_EN
//   defined   : t is registered into t_d every cycle, tt = t & ~t_d
//               (one toggle per rising edge of a t bit).
//   undefined : tt = t (level-sensitive toggles), no t_d register.
//
// Reset is asynchronous and active-low (reset=0 holds the bank in reset).
// Every output comes straight from a flop; no input reaches q or wrap
// combinationally.

module t_flipflop_bank #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic             wrap
);

   // Effective toggle vector after optional edge detection.
   logic [WIDTH-1:0] tt;

   // Candidate next values of q for each mode, and the next wrap value.
   logic [WIDTH-1:0] ind_next;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             carry;

`ifdef TFF_EDGE_DETECT_EN
   // Toggle history; registered on every edge regardless of en and load.
   logic [WIDTH-1:0] t_d;

   // Capture t each cycle so a held-high t toggles only once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_d <= '0;
      end else begin
         t_d <= t;
      end
   end

   assign tt = t & ~t_d;
`else
   assign tt = t;
`endif

   // Next-state selection: load first, then enable hold, then mode action.
   always_comb begin
      // Independent mode: every bit toggles on its own effective input.
      ind_next = q ^ tt;

      // Counter mode: ripple an enable-carry from bit 0 upward; bit i toggles
      // when tt[0] is set and every lower bit is already 1.
      carry    = tt[0];
      cnt_next = q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = q[i] ^ carry;
         carry       = carry & q[i];
      end

      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         q_next    = load_val;
         wrap_next = 1'b0;
      end else if (!en) begin
         q_next    = q;
         wrap_next = 1'b0;
      end else if (mode) begin
         q_next    = cnt_next;
         // Carry out of the top bit means all-ones rolled over to zero.
         wrap_next = carry;
      end else begin
         q_next    = ind_next;
         wrap_next = 1'b0;
      end
   end

   // State register for q and the wrap pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= RESET_VAL;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_t_flipflop_bank.sv
// Bench for t_flipflop_bank (WIDTH=4, RESET_VAL=0).
// Directed steps followed by a randomized run, all checked against a
// behavioural model that treats counter mode as plain modulo-16 addition
// and independent mode as XOR with the effective toggle vector.

module tb_t_flipflop_bank;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         mode;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] t;
   logic [W-1:0] q;
   logic         wrap;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state.
   logic [W-1:0] mq;
   logic         mw;
   logic [W-1:0] mtd;

   t_flipflop_bank #(
      .WIDTH    (W),
      .RESET_VAL(4'h0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .load    (load),
      .load_val(load_val),
      .t       (t),
      .q       (q),
      .wrap    (wrap)
   );

   // Clock: 10 ns period.
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model of one rising edge, from the inputs currently applied.
   task automatic model_edge();
      logic [W-1:0] tt;
`ifdef TFF_EDGE_DETECT_EN
      tt = t & ~mtd;
`else
      tt = t;
`endif
      if (load) begin
         mq = load_val;
         mw = 1'b0;
      end else if (!en) begin
         mw = 1'b0;
      end else if (mode) begin
         if (tt[0]) begin
            mw = (int'(mq) == (1 << W) - 1);
            mq = W'((int'(mq) + 1) % (1 << W));
         end else begin
            mw = 1'b0;
         end
      end else begin
         mq = mq ^ tt;
         mw = 1'b0;
      end
      mtd = t;
   endtask

   task automatic model_reset();
      mq  = '0;
      mw  = 1'b0;
      mtd = '0;
   endtask

   // Advance one clock and check q/wrap 1 ns after the edge.
   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ".q"}, q, mq);
      check({tag, ".wrap"}, W'(wrap), W'(mw));
   endtask

   task automatic drive(input logic e, input logic m, input logic l,
                        input logic [W-1:0] lv, input logic [W-1:0] tv);
      en       = e;
      mode     = m;
      load     = l;
      load_val = lv;
      t        = tv;
   endtask

   initial begin
      // Reset with clock running.
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      model_reset();
      #5;
      check("reset.q", q, 4'h0);
      check("reset.wrap", W'(wrap), '0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Step 1: independent toggle of bit 0 held two cycles.
      drive(1'b1, 1'b0, 1'b0, '0, 4'b0001);
      tick("s1.c1");
      check("s1.c1.const", q, 4'h1);
      tick("s1.c2");
`ifdef TFF_EDGE_DETECT_EN
      check("s1.c2.const", q, 4'h1);
`else
      check("s1.c2.const", q, 4'h0);
`endif
      t = '0;
      tick("s1.c3");

      // Step 2: counter mode from 0, 16 cycles of t[0]=1.
      load = 1'b1; load_val = '0;
      tick("s2.clr");
      drive(1'b1, 1'b1, 1'b0, '0, 4'b1111);
      for (int i = 1; i <= 16; i++) begin
         tick($sformatf("s2.c%0d", i));
`ifndef TFF_EDGE_DETECT_EN
         check($sformatf("s2.c%0d.const", i), q, W'(i % 16));
         check($sformatf("s2.c%0d.wrapc", i), W'(wrap), W'(i == 16));
`endif
      end
      t = '0;
      tick("s2.after");

      // Step 3: load with en=0, then hold for three cycles.
      drive(1'b0, 1'b1, 1'b1, 4'hA, 4'hF);
      tick("s3.load");
      check("s3.load.const", q, 4'hA);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick($sformatf("s3.hold%0d", i));
         check($sformatf("s3.hold%0d.const", i), q, 4'hA);
      end

      // Step 4: load beats a counter wrap on the same edge.
      drive(1'b1, 1'b1, 1'b1, 4'hF, 4'h0);
      tick("s4.setF");
      drive(1'b1, 1'b1, 1'b1, 4'h3, 4'h1);
      tick("s4.load");
      check("s4.load.const", q, 4'h3);
      check("s4.wrap.const", W'(wrap), '0);

      // Step 5: asynchronous reset mid-count at q=6.
      drive(1'b1, 1'b1, 1'b1, 4'h6, 4'h1);
      tick("s5.set6");
      load = 1'b0;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("s5.async.q", q, 4'h0);
      check("s5.async.wrap", W'(wrap), '0);
      @(posedge clk);
      #1;
      check("s5.held.q", q, 4'h0);
      reset = 1'b1;
      tick("s5.resume");
      check("s5.resume.const", q, 4'h1);

      // Step 6: independent mode all-ones to zero never wraps.
      drive(1'b1, 1'b0, 1'b1, 4'hF, 4'h0);
      tick("s6.setF");
      drive(1'b1, 1'b0, 1'b0, '0, 4'hF);
      tick("s6.tog");
`ifndef TFF_EDGE_DETECT_EN
      check("s6.tog.const", q, 4'h0);
`endif
      check("s6.wrap.const", W'(wrap), '0);

      // Randomized run against the model.
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 7) != 0);
         mode     = $urandom_range(0, 1);
         load     = ($urandom_range(0, 15) == 0);
         load_val = W'($urandom);
         t        = W'($urandom);
         if (mode && $urandom_range(0, 1)) t[0] = 1'b1;
         tick($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
